zxuno_regbank_port: RTL
=======================

# zxuno_regbank_port

Front-end for the ZX-UNO internal register bank, between the Z80 I/O bus and every register peripheral (device options, scandoubler, keymap, etc.). Decodes the address port FC3Bh and data port FD3Bh, holds the currently selected register number, and issues clean per-access read/write strobes. Downstream peripherals compare `zxuno_addr` against their own register number and act on `zxuno_regwr` / `zxuno_regrd`.

## Interface
- `ADDRPORT`, 16'hFC3B, I/O port that selects the register number
- `DATAPORT`, 16'hFD3B, I/O port that reads or writes the selected register
- `clk`  in  1  system clock; CPU bus signals are synchronous to it
- `rst`  in  1  synchronous, active-high reset
- `a`  in  16  CPU address bus
- `iorq_n`  in  1  CPU I/O request, active low
- `rd_n`  in  1  CPU read, active low
- `wr_n`  in  1  CPU write, active low
- `din`  in  8  CPU data bus (write data)
- `zxuno_addr`  out  8  selected register number
- `zxuno_regrd`  out  1  level: data-port read in progress
- `zxuno_regwr`  out  1  one-cycle pulse: data-port write
- `zxuno_regrd_done`  out  1  one-cycle pulse after a data-port read ends (for side-effect reads)
- `dout`  out  8  read-back data for the address port
- `oe_n`  out  1  active-low output enable for `dout`

## Operation
- Decode: `wracc` = !iorq_n & !wr_n & rd_n; `rdacc` = !iorq_n & !rd_n & wr_n. Both strobes low together: no access. Full 16-bit port compare.
- FSM states: IDLE, ACT, HOLD.
  - IDLE: on `wracc` or `rdacc` at ADDRPORT or DATAPORT, capture kind (addr-wr, addr-rd, data-wr, data-rd) and go to ACT. Any other port stays IDLE.
  - ACT (exactly 1 cycle): addr-wr loads `zxuno_addr` <= `din`; data-wr asserts `zxuno_regwr`; data-rd asserts `zxuno_regrd`. Go to HOLD.
  - HOLD: keep `zxuno_regrd` high for a data-rd; when `iorq_n` = 1 return to IDLE. For a data-rd, pulse `zxuno_regrd_done` in the cycle IDLE is re-entered.
- `din` is passed unchanged to peripherals and is stable during `zxuno_regwr`, since CPU cycles last ≥2 clocks.
- `zxuno_addr` changes only on an address-port write and persists across data accesses.
- Reset values: `zxuno_addr` = 8'h00, `zxuno_regwr` = 0, `zxuno_regrd` = 0, `zxuno_regrd_done` = 0, `oe_n` = 1, `dout` = 8'hFF, state = HOLD.
- Resetting into HOLD means a CPU cycle already active across reset release is ignored until `iorq_n` goes high. No spurious write after reset.
- Reset mid-access: all outputs return to reset values on the next edge. No `zxuno_regrd_done` is issued for the aborted read.
- Bus stays active longer than expected: one strobe per cycle only. Re-arm requires `iorq_n` high.

## Timing
- Detection edge E (first cycle `wracc`/`rdacc` seen in IDLE). ACT registered outputs are valid in cycle E+1.
- Address write: `zxuno_addr` updates at edge E+1. A data access in the immediately following CPU cycle sees the new value.
- Data write: `zxuno_regwr` high for cycle E+1 only. Latency 1 clock.
- Data read: `zxuno_regrd` high from E+1 through the last HOLD cycle (`iorq_n` high sampled). Peripheral `dout` must settle within that window.
- Back-to-back CPU cycles separated by ≥1 clock of `iorq_n` high are each recognised.

## Configuration
- `ZXUNO_ADDRREAD_EN` defined: a read of ADDRPORT drives `oe_n` = 0 and `dout` = `zxuno_addr` while `zxuno_regrd`-equivalent addr-rd is in ACT/HOLD.
- `ZXUNO_ADDRREAD_EN` undefined: ADDRPORT is write-only. `oe_n` stays 1 and `dout` stays 8'hFF always; the FSM still passes through ACT/HOLD for addr-rd, with no outputs.

## Test plan
- Reset held with `iorq_n`=0, `wr_n`=0, `a`=FD3Bh, then release while the bus is still active -> no `zxuno_regwr`. Bus idle, then a fresh write -> one pulse.
- OUT FC3Bh,0Eh (3-clock cycle) -> `zxuno_addr` = 8'h0E from E+1. No `zxuno_regwr`, no `zxuno_regrd`.
- OUT FD3Bh,5Ah (4-clock cycle) -> `zxuno_regwr` high exactly 1 clock at E+1 with `din` = 5Ah, `zxuno_addr` unchanged at 0Eh.
- IN FD3Bh (4-clock cycle) -> `zxuno_regrd` high E+1 until `iorq_n` rises. `zxuno_regrd_done` pulses once on return to IDLE.
- `iorq_n`=0 with `rd_n`=`wr_n`=0 at FD3Bh, then an access at port 00FEh -> no strobes, `zxuno_addr` unchanged.
- With `ZXUNO_ADDRREAD_EN`: after OUT FC3Bh,0Fh, IN FC3Bh -> `oe_n`=0, `dout`=0Fh during the access. Without the macro -> `oe_n`=1, `dout`=FFh.

Source files
------------

// File: rtl/zxuno_regbank_port.sv
// ZX-UNO register bank front-end: decodes FC3Bh (register select) and FD3Bh (register data).
// Optional macro ZXUNO_ADDRREAD_EN makes FC3Bh readable back through dout/oe_n.
module zxuno_regbank_port (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic [7:0]  din,
    output logic [7:0]  zxuno_addr,
    output logic        zxuno_regrd,
    output logic        zxuno_regwr,
    output logic        zxuno_regrd_done,
    output logic [7:0]  dout,
    output logic        oe_n
);

    localparam logic [15:0] ADDRPORT = 16'hFC3B;
    localparam logic [15:0] DATAPORT = 16'hFD3B;

    typedef enum logic [1:0] {IDLE, ACT, HOLD} state_t;
    // Encoding is {data_port, read} so it can be built straight from the decode.
    typedef enum logic [1:0] {K_ADDR_WR, K_ADDR_RD, K_DATA_WR, K_DATA_RD} kind_t;

    state_t state;
    kind_t  kind;

    logic wracc_c;
    logic rdacc_c;
    logic hit_addr_c;
    logic hit_data_c;

    assign wracc_c    = !iorq_n && !wr_n && rd_n;
    assign rdacc_c    = !iorq_n && !rd_n && wr_n;
    assign hit_addr_c = (a == ADDRPORT);
    assign hit_data_c = (a == DATAPORT);

    // Resetting into HOLD ignores any bus cycle still in flight at reset release.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= HOLD;
            kind             <= K_ADDR_WR;
            zxuno_addr       <= 8'h00;
            zxuno_regwr      <= 1'b0;
            zxuno_regrd      <= 1'b0;
            zxuno_regrd_done <= 1'b0;
`ifdef ZXUNO_ADDRREAD_EN
            oe_n             <= 1'b1;
            dout             <= 8'hFF;
`endif
        end else begin
            zxuno_regwr      <= 1'b0;
            zxuno_regrd_done <= 1'b0;
            case (state)
                IDLE: begin
                    if ((wracc_c || rdacc_c) && (hit_addr_c || hit_data_c)) begin
                        state <= ACT;
                        kind  <= kind_t'({hit_data_c, rdacc_c});
`ifdef ZXUNO_ADDRREAD_EN
                        if (hit_addr_c && rdacc_c) begin
                            oe_n <= 1'b0;
                            dout <= zxuno_addr;
                        end
`endif
                    end
                end
                ACT: begin
                    case (kind)
                        K_ADDR_WR: zxuno_addr  <= din;
                        K_DATA_WR: zxuno_regwr <= 1'b1;
                        K_DATA_RD: zxuno_regrd <= 1'b1;
                        default:   ;
                    endcase
                    state <= HOLD;
                end
                HOLD: begin
                    // Re-arm only once the CPU releases iorq_n.
                    if (iorq_n) begin
                        state            <= IDLE;
                        zxuno_regrd      <= 1'b0;
                        zxuno_regrd_done <= (kind == K_DATA_RD);
`ifdef ZXUNO_ADDRREAD_EN
                        oe_n             <= 1'b1;
                        dout             <= 8'hFF;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef ZXUNO_ADDRREAD_EN
    assign oe_n = 1'b1;
    assign dout = 8'hFF;
`endif

endmodule
